// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state/requester encodings and read latency for the SRAM access controller.
package sram_arb_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  typedef enum logic {REQ_A, REQ_B} req_id_e;
  localparam int RD_LAT = 2;
endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way arbiter; round-robin with SRAM_ARB_RR_EN defined, fixed priority (A first) otherwise.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic xfer_a,
  input  logic xfer_b,
  input  logic b_valid,
`endif
  input  logic a_valid,
  output logic grant_a,
  output logic grant_b
);
`ifdef SRAM_ARB_RR_EN
  req_id_e prio_q, prio_d;
  always_comb prio_d = xfer_a ? REQ_B : xfer_b ? REQ_A : prio_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) prio_q <= REQ_A;
    else prio_q <= prio_d;
  assign grant_a = ~b_valid | (prio_q == REQ_A);
  assign grant_b = ~a_valid | (prio_q == REQ_B);
`else
  assign grant_a = 1'b1;
  assign grant_b = ~a_valid;
`endif
endmodule

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: arbitrates two requesters onto a single-port-per-direction SRAM, one op per cycle, with a zeroing sweep.
// Arbitration policy selected by SRAM_ARB_RR_EN (round-robin when defined, fixed A-first otherwise).
module sram_arb_ctrl
  import sram_arb_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [WIDTH-1:0]  a_req_wdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [WIDTH-1:0]  b_req_wdata,
  output logic              a_rsp_valid,
  output logic [WIDTH-1:0]  a_rsp_rdata,
  output logic              b_rsp_valid,
  output logic [WIDTH-1:0]  b_rsp_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  input  logic [WIDTH-1:0]  mem_rd_data
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic wren_q, wren_d, rden_q, rden_d, done_q, done_d;
  logic [RD_LAT-1:0] rv_q, rv_d, rid_q, rid_d;
  logic grant_a, grant_b, xfer_a, xfer_b, sel_we;
  logic [ADDR_W-1:0] sel_addr;

  sram_rr_arb2 u_arb (
`ifdef SRAM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .xfer_a  (xfer_a),
    .xfer_b  (xfer_b),
    .b_valid (b_req_valid),
`endif
    .a_valid (a_req_valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a_req_ready = (state_q == IDLE) & ~clr_start & grant_a;
  assign b_req_ready = (state_q == IDLE) & ~clr_start & grant_b;
  assign xfer_a = a_req_valid & a_req_ready;
  assign xfer_b = b_req_valid & b_req_ready;
  assign sel_we = xfer_a ? a_req_we : b_req_we;
  assign sel_addr = xfer_a ? a_req_addr : b_req_addr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == CLEAR) begin
      wren_d    = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
    end else if (clr_start) begin
      // address 0 is written on the start edge, so CLEAR continues from 1
      state_d   = CLEAR;
      wren_d    = 1'b1;
      wr_addr_d = '0;
      wr_data_d = '0;
      cnt_d     = ADDR_W'(1);
    end else if (xfer_a | xfer_b) begin
      wren_d    = sel_we;
      rden_d    = ~sel_we;
      wr_addr_d = sel_we ? sel_addr : wr_addr_q;
      rd_addr_d = sel_we ? rd_addr_q : sel_addr;
      wr_data_d = sel_we ? (xfer_a ? a_req_wdata : b_req_wdata) : wr_data_q;
    end
    rv_d  = {rv_q[RD_LAT-2:0], rden_d};
    rid_d = {rid_q[RD_LAT-2:0], xfer_b};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      rv_q      <= '0;
      rid_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      done_q    <= done_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      rv_q      <= rv_d;
      rid_q     <= rid_d;
    end

  assign mem_wren    = wren_q;
  assign mem_rden    = rden_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_data = wr_data_q;
  assign clr_busy    = (state_q == CLEAR) | done_q;
  assign clr_done    = done_q;
  assign a_rsp_valid = rv_q[RD_LAT-1] & (rid_q[RD_LAT-1] == REQ_A);
  assign b_rsp_valid = rv_q[RD_LAT-1] & (rid_q[RD_LAT-1] == REQ_B);
  assign a_rsp_rdata = a_rsp_valid ? mem_rd_data : '0;
  assign b_rsp_rdata = b_rsp_valid ? mem_rd_data : '0;
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: randomized scoreboard bench for sram_arb_ctrl against a behavioural arbitration/memory model.
module tb_sram_arb_ctrl;
  localparam int W = 32;
  localparam int D = 16;
  localparam int AW = 4;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req_valid = 0, a_req_we = 0, b_req_valid = 0, b_req_we = 0, clr_start = 0;
  logic [AW-1:0] a_req_addr = '0, b_req_addr = '0;
  logic [W-1:0] a_req_wdata = '0, b_req_wdata = '0;
  logic a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, clr_busy, clr_done;
  logic [W-1:0] a_rsp_rdata, b_rsp_rdata, mem_wr_data;
  logic [W-1:0] mem_rd_data = '0;
  logic mem_wren, mem_rden;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;

  always #5 clk = ~clk;

  sram_arb_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  logic [W-1:0] sram [D];
  always @(posedge clk) begin
    if (mem_wren) sram[mem_wr_addr] <= mem_wr_data;
    if (mem_rden) mem_rd_data <= sram[mem_rd_addr];
  end

  typedef struct {
    bit           id;
    logic [W-1:0] data;
    time          due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int both_en = 0;
  logic [W-1:0] ref_mem [D];
  bit prio_b = 1'b0;
  int clr_t = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_wren && mem_rden) both_en++;
    if (a_rsp_valid || b_rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: a_rsp_valid=%0b b_rsp_valid=%0b with nothing expected at %0t", a_rsp_valid, b_rsp_valid, $time);
      end else begin
        e = q.pop_front();
        chk("rsp_a_valid", a_rsp_valid, !e.id);
        chk("rsp_b_valid", b_rsp_valid, e.id);
        chk("rsp_data", e.id ? b_rsp_rdata : a_rsp_rdata, e.data);
        chk("rsp_time", $time, e.due);
      end
    end
  end

  task automatic step(input bit av, input bit aw, input int aa, input logic [W-1:0] ad,
                      input bit bv, input bit bw, input int ba, input logic [W-1:0] bd, input bit cs);
    bit sweeping, ga, gb, ea, eb, acc_a, acc_b;
    a_req_valid = av; a_req_we = aw; a_req_addr = AW'(aa); a_req_wdata = ad;
    b_req_valid = bv; b_req_we = bw; b_req_addr = AW'(ba); b_req_wdata = bd;
    clr_start = cs;
    #1;
    sweeping = clr_t >= 0 && clr_t <= D - 2;
    ga = RR ? (!bv || !prio_b) : 1'b1;
    gb = !av || (RR && prio_b);
    ea = !sweeping && !cs && ga;
    eb = !sweeping && !cs && gb;
    chk("a_req_ready", a_req_ready, ea);
    chk("b_req_ready", b_req_ready, eb);
    chk("clr_busy", clr_busy, clr_t >= 0);
    chk("clr_done", clr_done, clr_t == D - 1);
    acc_a = av && ea;
    acc_b = bv && eb;
    @(posedge clk);
    if (acc_a) begin
      if (aw) ref_mem[aa] = ad;
      else q.push_back('{1'b0, ref_mem[aa], $time + 15});
      prio_b = 1'b1;
    end else if (acc_b) begin
      if (bw) ref_mem[ba] = bd;
      else q.push_back('{1'b1, ref_mem[ba], $time + 15});
      prio_b = 1'b0;
    end
    if (cs && !sweeping) begin
      clr_t = 0;
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
    end else if (clr_t == D - 1) clr_t = -1;
    else if (clr_t >= 0) clr_t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req_valid = 0; b_req_valid = 0; clr_start = 0;
    q.delete();
    clr_t = -1;
    prio_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    chk("rst_rsp_rdata", {a_rsp_rdata, b_rsp_rdata}, 0);
    chk("rst_clr", {clr_busy, clr_done}, 0);
  endtask

  initial begin
    do_reset();
    // initial sweep gives the array a known all-zero state
    step(0, 0, 0, '0, 0, 0, 0, '0, 1);
    idle(D + 1);
    // write then read back on A
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0, 0);
    step(1, 0, 5, '0, 0, 0, 0, '0, 0);
    idle(3);
    // write on A immediately followed by read of the same word on B
    step(1, 1, 7, 32'h1234, 0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1, 0, 7, '0, 0);
    idle(3);
    // contention: both read every cycle, then B alone
    repeat (6) step(1, 0, 1, '0, 1, 0, 2, '0, 0);
    repeat (3) step(0, 0, 0, '0, 1, 0, 2, '0, 0);
    idle(2);
    // fill, sweep (with a clr_start pulse mid-sweep that must be ignored), read back zeros
    for (int i = 0; i < 4; i++) step(1, 1, i, 32'hA5A50000 + i + 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, i, '0, 0, 0, 0, '0, 0);
    step(1, 0, 1, '0, 1, 0, 2, '0, 1);
    idle(4);
    step(0, 0, 0, '0, 0, 0, 0, '0, 1);
    repeat (D) step(1, 0, 0, '0, 1, 1, 3, 32'hFFFF, 0);
    for (int i = 0; i < 4; i++) step(1, 0, i, '0, 0, 0, 0, '0, 0);
    idle(3);
    // randomized traffic
    repeat (600)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, D - 1), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, D - 1), $urandom,
           $urandom_range(0, 59) == 0);
    idle(D + 2);
    // reset while a read is in flight: the response must be dropped
    step(1, 0, 3, '0, 0, 0, 0, '0, 0);
    do_reset();
    idle(4);
    step(1, 0, 1, '0, 1, 0, 2, '0, 0);
    step(1, 0, 1, '0, 1, 0, 2, '0, 0);
    idle(4);
    chk("both_enables", both_en, 0);
    chk("rsp_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Two-requester access controller for the team's single-clock SRAM macro (separate write/read address ports, registered read data). It arbitrates two requesters onto the SRAM and issues at most one operation per cycle, so the macro never sees simultaneous write and read enables. It returns read data to the requester that issued the read and provides a hardware clear sweep that zeroes the whole array.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 1024, number of words; ADDR_W = $clog2(DEPTH), derived
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_req_valid / b_req_valid  in  1  request valid, per requester
- a_req_ready / b_req_ready  out  1  request accepted this cycle
- a_req_we / b_req_we  in  1  1 = write, 0 = read
- a_req_addr / b_req_addr  in  ADDR_W  word address
- a_req_wdata / b_req_wdata  in  WIDTH  write data
- a_rsp_valid / b_rsp_valid  out  1  one-cycle read-response strobe
- a_rsp_rdata / b_rsp_rdata  out  WIDTH  read data, valid only with the matching rsp_valid
- clr_start  in  1  pulse that requests a full-array zero sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse after the last address has been written
- mem_wren, mem_rden  out  1  SRAM enables; never both high
- mem_wr_addr, mem_rd_addr  out  ADDR_W  SRAM addresses
- mem_wr_data  out  WIDTH  SRAM write data
- mem_rd_data  in  WIDTH  SRAM registered read data

## Operation
- FSM states:
  - IDLE: serves requests.
  - CLEAR: runs the sweep.
- IDLE→CLEAR on clr_start. CLEAR→IDLE after the address DEPTH-1 write issues. clr_start in CLEAR is ignored.
- Readiness:
  - x_req_ready = (state==IDLE) & ~clr_start & grant_x.
  - Ready never depends on the requester's own valid.
  - A transfer happens when valid & ready are both high at a rising edge.
- Grant:
  - Priority pointer prio (A or B).
  - grant_a = ~b_req_valid | prio==A.
  - grant_b = ~a_req_valid | prio==B.
  - When both requesters are valid, exactly one is granted.
- Pointer update: after an accepted transfer, prio moves to the other requester. With no transfer, prio is unchanged.
- Issue:
  - The accepted request is registered onto the mem_* outputs for one cycle.
  - A write drives mem_wren=1, mem_wr_addr, mem_wr_data.
  - A read drives mem_rden=1, mem_rd_addr.
  - With no transfer, both enables are 0 and the address/data registers hold.
- Response:
  - A two-stage valid/id pipeline tracks each issued read.
  - x_rsp_valid=1 for exactly one cycle; x_rsp_rdata = mem_rd_data (pass-through).
  - There is no response backpressure.
- Clear sweep:
  - A counter runs 0..DEPTH-1.
  - Each cycle drives mem_wren=1, mem_wr_addr=count, mem_wr_data=0.
  - Both readies are low throughout.
  - Read responses already in flight complete normally.
- Reset values:
  - All outputs 0.
  - state=IDLE, prio=A, clear counter=0, response pipeline empty.
- Reset mid-sweep or mid-read: in-flight responses are dropped and the sweep is abandoned. SRAM contents are not touched by this block.

## Timing
- Read latency: accepted at edge N → mem_rden high N..N+1 → SRAM captures at N+1 → x_rsp_valid high N+1..N+2.
- Write: mem_wren high N..N+1; the SRAM array updates at edge N+1.
- Write at N followed by a read of the same address accepted at N+1 returns the new data. No hazard logic is needed.
- Throughput: one operation per cycle in total, shared by A and B.
- Sweep: clr_start high at edge N → clr_busy high from N to N+DEPTH. Writes to addresses 0..DEPTH-1 are issued in cycles N..N+DEPTH-1. clr_done pulses in cycle N+DEPTH-1..N+DEPTH. Requests are accepted again from edge N+DEPTH.
- Simultaneous clr_start and valid requests in IDLE: the sweep wins and no request is accepted that cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration as described under Operation.
- SRAM_ARB_RR_EN undefined: fixed priority.
  - prio is held at A; grant_a = 1, grant_b = ~a_req_valid.
  - The pointer register is not built.

## Structure
- Package sram_arb_pkg:
  - state enum {IDLE, CLEAR}
  - requester id typedef {REQ_A, REQ_B}
  - the read-latency constant (2)
- Sub-module sram_rr_arb2: two-way arbiter holding prio, producing grant_a/grant_b; the macro is applied inside it.
- The top level holds the FSM, sweep counter, mem_* issue registers and response pipeline.

## Test plan
- Write/read-back: A writes 0xDEADBEEF to address 5, then reads 5 → a_rsp_valid 2 cycles after acceptance with 0xDEADBEEF; b_rsp_valid stays 0.
- Contention (RR): A and B both valid every cycle, reading addresses 1 and 2 → grants alternate A,B,A,B starting with A after reset; mem_wren&mem_rden never both 1.
- Fixed priority (macro off): the same stimulus → A is granted every cycle and B only after A deasserts valid.
- Back-to-back hazard: A writes 0x1234 to address 7; B reads 7 the next cycle → b_rsp_rdata = 0x1234.
- Clear: fill addresses 0..3 with nonzero data, pulse clr_start (DEPTH=16) → readies low for 16 cycles, clr_done after 16 cycles, then reads of 0..3 return 0.
- Reset mid-read: assert rst one cycle after a read is accepted → no rsp_valid appears; all outputs 0 and prio=A after release.
